// File: rtl/put_fsm.sv
// rtl/put_fsm.sv - PUT sub-command FSM: target slot select plus one entry-memory write
// Define PUT_EVICT_EN to overwrite evict_idx on a full miss instead of failing.
module put_fsm #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             enter,
  input  logic             hit,
  input  logic [IDX_W-1:0] hit_idx,
  input  logic             full,
  input  logic [IDX_W-1:0] free_idx,
  input  logic [IDX_W-1:0] evict_idx,
  output logic             mem_wr_req,
  output logic [IDX_W-1:0] mem_wr_idx,
  output logic             mem_wr_key,
  output logic             mem_set_valid,
  input  logic             mem_wr_ack,
  output logic             done,
  output logic             rdy_out,
  output logic             op_succ,
  output logic             evicted
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    PUT_ST_START,
    PUT_ST_WRITE,
    PUT_ST_DONE,
    PUT_ST_ERR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] tgt_idx;
  logic             new_f;
  logic             evict_f;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PUT_ST_START;
      tgt_idx <= '0;
      new_f   <= 1'b0;
      evict_f <= 1'b0;
      cnt     <= '0;
    end else if (enter) begin
      state   <= PUT_ST_START;
      cnt     <= '0;
      new_f   <= 1'b0;
      evict_f <= 1'b0;
    end else if (en) begin
      case (state)
        PUT_ST_START: begin
          if (hit) begin
            tgt_idx <= hit_idx;
            new_f   <= 1'b0;
            evict_f <= 1'b0;
            state   <= PUT_ST_WRITE;
          end else if (!full) begin
            tgt_idx <= free_idx;
            new_f   <= 1'b1;
            evict_f <= 1'b0;
            state   <= PUT_ST_WRITE;
          end else begin
`ifdef PUT_EVICT_EN
            tgt_idx <= evict_idx;
            new_f   <= 1'b1;
            evict_f <= 1'b1;
            state   <= PUT_ST_WRITE;
`else
            state   <= PUT_ST_ERR;
`endif
          end
        end
        // req is en-gated, so ack seen here always belongs to a live request
        PUT_ST_WRITE: begin
          if (mem_wr_ack) begin
            state <= PUT_ST_DONE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PUT_ST_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef PUT_EVICT_EN
  logic unused_evict_idx;
  assign unused_evict_idx = ^evict_idx;
`endif

  logic in_write;
  assign in_write      = (state == PUT_ST_WRITE);
  assign mem_wr_req    = in_write & en;
  assign mem_wr_idx    = in_write ? tgt_idx : '0;
  assign mem_wr_key    = in_write & new_f;
  assign mem_set_valid = in_write & new_f;
  assign done          = (state == PUT_ST_DONE) | (state == PUT_ST_ERR);
  assign rdy_out       = done;
  assign op_succ       = (state == PUT_ST_DONE);
  assign evicted       = (state == PUT_ST_DONE) & evict_f;

endmodule

// File: tb/tb_put_fsm.sv
// tb/tb_put_fsm.sv - directed vector table plus hand sequences for put_fsm
module tb_put_fsm;

  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, en, enter, hit, full, mem_wr_ack;
  logic [IDX_W-1:0] hit_idx, free_idx, evict_idx;
  logic             mem_wr_req, mem_wr_key, mem_set_valid;
  logic [IDX_W-1:0] mem_wr_idx;
  logic             done, rdy_out, op_succ, evicted;

  int checks = 0;
  int errors = 0;

  put_fsm #(.NUM_ENTRIES(16), .IDX_W(IDX_W), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .enter(enter), .hit(hit), .hit_idx(hit_idx),
    .full(full), .free_idx(free_idx), .evict_idx(evict_idx), .mem_wr_req(mem_wr_req),
    .mem_wr_idx(mem_wr_idx), .mem_wr_key(mem_wr_key), .mem_set_valid(mem_set_valid),
    .mem_wr_ack(mem_wr_ack), .done(done), .rdy_out(rdy_out), .op_succ(op_succ),
    .evicted(evicted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n, enter, en, hit, full, ack;
    logic [IDX_W-1:0] hit_idx, free_idx, evict_idx;
    logic [9:0]       exp;   // {req, idx[3:0], key, set_valid, done, rdy_out, op_succ, evicted} minus one bit
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int r, input int ent, input int e, input int h, input int hi,
                     input int f, input int fi, input int ei, input int a,
                     input int req, input int idx, input int key, input int sv,
                     input int dn, input int sc, input int ev);
    vec_t v;
    v.rst_n = 1'(r); v.enter = 1'(ent); v.en = 1'(e); v.hit = 1'(h); v.full = 1'(f);
    v.ack = 1'(a); v.hit_idx = 4'(hi); v.free_idx = 4'(fi); v.evict_idx = 4'(ei);
    v.exp = {1'(req), 4'(idx), 1'(key), 1'(sv), 1'(dn), 1'(sc), 1'(ev)};
    vecs.push_back(v);
  endtask

  function automatic logic [9:0] observed();
    return {mem_wr_req, mem_wr_idx, mem_wr_key, mem_set_valid, done, op_succ, evicted};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; enter = v.enter; en = v.en; hit = v.hit; full = v.full;
    mem_wr_ack = v.ack; hit_idx = v.hit_idx; free_idx = v.free_idx; evict_idx = v.evict_idx;
  endtask

  initial begin
    int n;
    int req_cnt;
    bit seen;

    rst_n = 1'b0; enter = 1'b0; en = 1'b0; hit = 1'b0; full = 1'b0; mem_wr_ack = 1'b0;
    hit_idx = '0; free_idx = '0; evict_idx = '0;

    // rst enter en hit hidx full fidx eidx ack | req idx key sv done succ ev
    add(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    add(1,1,1,1,5,0,0,0,0, 0,0,0,0,0,0,0);
    add(1,0,1,1,5,0,0,0,0, 0,0,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,1, 1,5,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 0,0,0,0,1,1,0);
    add(1,0,0,0,0,0,0,0,1, 0,0,0,0,1,1,0);
    add(1,1,1,0,0,0,9,0,0, 0,0,0,0,1,1,0);
    add(1,0,1,0,0,0,9,0,0, 0,0,0,0,0,0,0);
    add(1,0,1,0,0,0,9,0,0, 1,9,1,1,0,0,0);
    add(1,0,1,0,0,0,9,0,0, 1,9,1,1,0,0,0);
    add(1,0,1,0,0,0,9,0,1, 1,9,1,1,0,0,0);
    add(1,0,0,0,0,0,0,0,0, 0,0,0,0,1,1,0);
    add(1,1,1,0,0,1,0,2,0, 0,0,0,0,1,1,0);
    add(1,0,1,0,0,1,0,2,0, 0,0,0,0,0,0,0);
`ifdef PUT_EVICT_EN
    add(1,0,1,0,0,1,0,2,1, 1,2,1,1,0,0,0);
    add(1,0,0,0,0,0,0,0,0, 0,0,0,0,1,1,1);
    add(1,1,0,0,0,0,0,0,0, 0,0,0,0,1,1,1);
`else
    add(1,0,1,0,0,0,0,0,0, 0,0,0,0,1,0,0);
    add(1,1,0,0,0,0,0,0,0, 0,0,0,0,1,0,0);
`endif
    // hit beats full, then en toggling in WRITE and a 4-cycle timeout
    add(1,0,1,1,3,1,9,0,0, 0,0,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 1,3,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,1, 0,3,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 1,3,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0, 0,3,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 1,3,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 1,3,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0);
    // ack on the last allowed cycle
    add(1,1,1,1,7,0,0,0,0, 0,0,0,0,1,0,0);
    add(1,0,1,1,7,0,0,0,0, 0,0,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 1,7,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 1,7,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 1,7,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,1, 1,7,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0, 0,0,0,0,1,1,0);
    // abort by enter during WRITE, late ack ignored
    add(1,1,1,0,0,0,4,0,0, 0,0,0,0,1,1,0);
    add(1,0,1,0,0,0,4,0,0, 0,0,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 1,4,1,1,0,0,0);
    add(1,1,1,0,0,0,0,0,0, 1,4,1,1,0,0,0);
    add(1,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    // reset held two cycles mid-WRITE
    add(1,0,1,1,6,0,0,0,0, 0,0,0,0,0,0,0);
    add(1,0,1,0,0,0,0,0,0, 1,6,0,0,0,0,0);
    add(0,0,1,0,0,0,0,0,0, 1,6,0,0,0,0,0);
    add(0,0,1,0,0,0,0,0,1, 0,0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), int'(observed()), int'(vecs[i].exp));
      check($sformatf("vec%0d_rdy", i), int'(rdy_out), int'(vecs[i].exp[2]));
      @(posedge clk); #1;
    end

    // hit with ack on first req cycle: done two en-cycles after enter
    rst_n = 1'b1; enter = 1'b1; en = 1'b1; hit = 1'b1; hit_idx = 4'd5; full = 1'b0; mem_wr_ack = 1'b1;
    @(posedge clk); #1;
    enter = 1'b0;
    n = 0; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
      seen = done;
    end
    check("latency_done_seen", int'(seen), 1);
    check("latency_cycles", n, 2);
    check("latency_succ", int'(op_succ), 1);

    // no ack: req high exactly ACK_TIMEOUT en-cycles then ERR
    @(posedge clk); #1;
    enter = 1'b1; en = 1'b1; hit = 1'b0; full = 1'b0; free_idx = 4'd11; mem_wr_ack = 1'b0;
    @(posedge clk); #1;
    enter = 1'b0;
    req_cnt = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (mem_wr_req) begin
          req_cnt++;
          if (mem_wr_idx != 4'd11 || !mem_wr_key) begin
            errors++;
            $display("FAIL timeout_req_fields: idx %0d key %0d expected idx 11 key 1", mem_wr_idx, mem_wr_key);
          end
        end
        @(posedge clk); #1;
      end
    end
    check("timeout_done_seen", int'(seen), 1);
    check("timeout_req_cycles", req_cnt, 4);
    check("timeout_succ", int'(op_succ), 0);
    check("timeout_rdy", int'(rdy_out), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
